// File: rtl/dice_reader.sv
`timescale 1ns/1ps
// dice_reader: samples the dice roller's LED bus, follows each roll until the
// display settles, decodes the settled seven-segment pattern to a face 1..6,
// and presents it on a valid/ready handshake with saturating per-face tallies.
module dice_reader #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [7:0]       LEDS,
   output logic [2:0]       RESULT,
   output logic             ERR,
   output logic             VALID,
   input  logic             READY,
   output logic             OVR,
   input  logic [2:0]       HIST_SEL,
   output logic [CNT_W-1:0] HIST_CNT,
   output logic [CNT_W-1:0] ROLLS
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ROLLING = 2'd1,
      S_SETTLE  = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       ledq_q;
   logic [6:0]       snap_q, snap_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [2:0]       result_q, result_d;
   logic             err_q, err_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic [CNT_W-1:0] rolls_q, rolls_d;
   logic [CNT_W-1:0] tally_q [0:6];
   logic [CNT_W-1:0] tally_d [0:6];
   logic [2:0]       face_s;
   logic [CNT_W-1:0] hist_s;

   // Segment pattern (bit 0 = a) to face; 0 marks an illegal pattern.
   function automatic logic [2:0] decode_face(input logic [6:0] seg);
      case (seg)
         7'b0000110: decode_face = 3'd1;
         7'b1011011: decode_face = 3'd2;
         7'b1001111: decode_face = 3'd3;
         7'b1100110: decode_face = 3'd4;
         7'b1101101: decode_face = 3'd5;
         7'b1111100: decode_face = 3'd6;
         default:    decode_face = 3'd0;
      endcase
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         sat_inc = v;
      end else begin
         sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   assign face_s = decode_face(ledq_q[6:0]);

   // Roll tracking FSM: next state, settle counter, result latch and tallies.
   always_comb begin
      state_d  = state_q;
      snap_d   = snap_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      err_d    = err_q;
      valid_d  = valid_q;
      ovr_d    = ovr_q;
      rolls_d  = rolls_q;
      for (int i = 0; i < 7; i++) begin
         tally_d[i] = tally_q[i];
      end
      case (state_q)
         S_IDLE: begin
            if (!ledq_q[7]) begin
               state_d = S_ROLLING;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ROLLING: begin
            if (ledq_q[7]) begin
               state_d = S_SETTLE;
               snap_d  = ledq_q[6:0];
               cnt_d   = 8'd1;
            end else begin
               state_d = S_ROLLING;
            end
         end
         S_SETTLE: begin
            if (!ledq_q[7]) begin
               // Decimal point dropped again: the roll restarted.
               state_d = S_ROLLING;
            end else if (ledq_q[6:0] != snap_q) begin
               snap_d = ledq_q[6:0];
               cnt_d  = 8'd1;
            end else if (cnt_q == 8'(STABLE_CYCLES - 1)) begin
               state_d  = S_HOLD;
               result_d = face_s;
               err_d    = (face_s == 3'd0);
               valid_d  = 1'b1;
               rolls_d  = sat_inc(rolls_q);
               // Illegal patterns decode to 0, which is the error tally slot.
               for (int i = 0; i < 7; i++) begin
                  if (face_s == 3'(i)) begin
                     tally_d[i] = sat_inc(tally_q[i]);
                  end
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            if (!ledq_q[7]) begin
               ovr_d = 1'b1;
            end else begin
               ovr_d = ovr_q;
            end
            if (READY) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and data registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         ledq_q   <= 8'd0;
         snap_q   <= 7'd0;
         cnt_q    <= 8'd0;
         result_q <= 3'd0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
         rolls_q  <= '0;
         for (int i = 0; i < 7; i++) begin
            tally_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         ledq_q   <= LEDS;
         snap_q   <= snap_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
         rolls_q  <= rolls_d;
         for (int i = 0; i < 7; i++) begin
            tally_q[i] <= tally_d[i];
         end
      end
   end

   // Tally read mux; select 7 has no tally and reads zero.
   always_comb begin
      hist_s = '0;
      for (int i = 0; i < 7; i++) begin
         if (HIST_SEL == 3'(i)) begin
            hist_s = tally_q[i];
         end
      end
   end

   assign RESULT   = result_q;
   assign ERR      = err_q;
   assign VALID    = valid_q;
   assign OVR      = ovr_q;
   assign ROLLS    = rolls_q;
   assign HIST_CNT = hist_s;

endmodule

// File: tb/tb_dice_reader.sv
`timescale 1ns/1ps
// Self-checking bench for dice_reader: directed scenarios plus randomized
// rolls checked against a table-driven reference model.
module tb_dice_reader;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  LEDS;
   logic        READY;
   logic [2:0]  HIST_SEL;
   logic [2:0]  RESULT;
   logic        ERR, VALID, OVR;
   logic [15:0] HIST_CNT, ROLLS;

   logic        rst2;
   logic [7:0]  leds2;
   logic        ready2;
   logic [2:0]  sel2;
   logic [2:0]  result2;
   logic        err2, valid2, ovr2;
   logic [1:0]  hist2, rolls2;

   int n_vec = 0;
   int n_err = 0;
   int m_tally [0:6];
   int m_rolls;
   logic m_ovr;

   always #5 CLK = ~CLK;

   dice_reader #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .LEDS(LEDS), .RESULT(RESULT), .ERR(ERR),
      .VALID(VALID), .READY(READY), .OVR(OVR), .HIST_SEL(HIST_SEL),
      .HIST_CNT(HIST_CNT), .ROLLS(ROLLS)
   );

   dice_reader #(.STABLE_CYCLES(4), .CNT_W(2)) dut2 (
      .CLK(CLK), .RST(rst2), .LEDS(leds2), .RESULT(result2), .ERR(err2),
      .VALID(valid2), .READY(ready2), .OVR(ovr2), .HIST_SEL(sel2),
      .HIST_CNT(hist2), .ROLLS(rolls2)
   );

   // Reference decode: look the pattern up in the table of legal faces.
   function automatic int ref_face(input logic [6:0] s);
      logic [6:0] tbl [6];
      tbl = '{7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101, 7'b1111100};
      ref_face = 0;
      for (int i = 0; i < 6; i++) begin
         if (tbl[i] == s) ref_face = i + 1;
      end
   endfunction

   function automatic logic [6:0] face_pattern(input int f);
      logic [6:0] tbl [6];
      tbl = '{7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101, 7'b1111100};
      face_pattern = tbl[f-1];
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_result(input logic [6:0] segs);
      int f;
      f = ref_face(segs);
      if (m_tally[f] < 65535) m_tally[f]++;
      if (m_rolls < 65535) m_rolls++;
   endtask

   task automatic do_reset();
      RST = 1'b1; LEDS = 8'h00; READY = 1'b0; HIST_SEL = 3'd0;
      tick(); tick();
      RST = 1'b0;
      for (int i = 0; i < 7; i++) m_tally[i] = 0;
      m_rolls = 0;
      m_ovr = 1'b0;
   endtask

   // Roll: dp low for dp0 cycles, optional unstable dp-high pattern, then final.
   // lat counts edges from the final pattern appearing until VALID rises.
   task automatic run_roll(input logic [7:0] roll_leds, input int dp0,
                           input logic [6:0] pre, input int pre_n,
                           input logic [6:0] segs, output int lat);
      LEDS = roll_leds;
      repeat (dp0) tick();
      if (pre_n > 0) begin
         LEDS = {1'b1, pre};
         repeat (pre_n) tick();
      end
      LEDS = {1'b1, segs};
      lat = 0;
      while (!VALID && lat < 20) begin
         tick();
         lat++;
      end
      model_result(segs);
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (RESULT !== 3'd0) begin n_err++; $display("FAIL reset_result: got %0d expected 0", RESULT); end
      n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0d expected 0", ERR); end
      n_vec++; if (VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0d expected 0", VALID); end
      n_vec++; if (OVR !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %0d expected 0", OVR); end
      n_vec++; if (ROLLS !== 16'd0) begin n_err++; $display("FAIL reset_rolls: got %0d expected 0", ROLLS); end
      for (int s = 0; s < 8; s++) begin
         HIST_SEL = 3'(s); #1;
         n_vec++; if (HIST_CNT !== 16'd0) begin n_err++; $display("FAIL reset_hist sel=%0d: got %0d expected 0", s, HIST_CNT); end
      end
   endtask

   task automatic test_basic();
      int lat;
      do_reset();
      run_roll(8'h5B, 10, 7'd0, 0, 7'b1100110, lat);
      HIST_SEL = 3'd4; #1;
      n_vec++; if (lat !== 5) begin n_err++; $display("FAIL basic_latency: got %0d expected 5", lat); end
      n_vec++; if (VALID !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0d expected 1", VALID); end
      n_vec++; if (RESULT !== 3'd4) begin n_err++; $display("FAIL basic_result: got %0d expected 4", RESULT); end
      n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL basic_err: got %0d expected 0", ERR); end
      n_vec++; if (ROLLS !== 16'(m_rolls)) begin n_err++; $display("FAIL basic_rolls: got %0d expected %0d", ROLLS, m_rolls); end
      n_vec++; if (HIST_CNT !== 16'(m_tally[4])) begin n_err++; $display("FAIL basic_hist4: got %0d expected %0d", HIST_CNT, m_tally[4]); end
      READY = 1'b1; tick(); READY = 1'b0;
      n_vec++; if (VALID !== 1'b0) begin n_err++; $display("FAIL basic_accept: got %0d expected 0", VALID); end
   endtask

   task automatic test_hold();
      int lat;
      run_roll(8'h5B, 3, 7'd0, 0, 7'b1111100, lat);
      n_vec++; if (lat !== 5) begin n_err++; $display("FAIL hold_latency: got %0d expected 5", lat); end
      for (int i = 0; i < 20; i++) begin
         n_vec++; if (VALID !== 1'b1 || RESULT !== 3'd6 || ERR !== 1'b0) begin
            n_err++; $display("FAIL hold_stable cyc=%0d: got v=%0d r=%0d e=%0d expected v=1 r=6 e=0", i, VALID, RESULT, ERR);
         end
         tick();
      end
      READY = 1'b1; tick(); READY = 1'b0;
      n_vec++; if (VALID !== 1'b0) begin n_err++; $display("FAIL hold_accept: got %0d expected 0", VALID); end
      // Display stays settled: an idle reader must not produce another result.
      repeat (10) tick();
      n_vec++; if (VALID !== 1'b0) begin n_err++; $display("FAIL hold_idle: got %0d expected 0", VALID); end
   endtask

   task automatic test_error();
      int lat;
      do_reset();
      run_roll(8'h5B, 4, 7'd0, 0, 7'b0111111, lat);
      HIST_SEL = 3'd0; #1;
      n_vec++; if (lat !== 5) begin n_err++; $display("FAIL err_latency: got %0d expected 5", lat); end
      n_vec++; if (RESULT !== 3'd0 || ERR !== 1'b1) begin n_err++; $display("FAIL err_flags: got r=%0d e=%0d expected r=0 e=1", RESULT, ERR); end
      n_vec++; if (HIST_CNT !== 16'd1) begin n_err++; $display("FAIL err_tally: got %0d expected 1", HIST_CNT); end
      n_vec++; if (ROLLS !== 16'd1) begin n_err++; $display("FAIL err_rolls: got %0d expected 1", ROLLS); end
      for (int s = 1; s <= 6; s++) begin
         HIST_SEL = 3'(s); #1;
         n_vec++; if (HIST_CNT !== 16'd0) begin n_err++; $display("FAIL err_face_tally sel=%0d: got %0d expected 0", s, HIST_CNT); end
      end
      READY = 1'b1; tick(); READY = 1'b0;
   endtask

   task automatic test_instability();
      int lat;
      run_roll(8'h5B, 3, 7'b0000110, 2, 7'b1011011, lat);
      n_vec++; if (lat !== 5) begin n_err++; $display("FAIL unstable_latency: got %0d expected 5", lat); end
      n_vec++; if (RESULT !== 3'd2) begin n_err++; $display("FAIL unstable_result: got %0d expected 2", RESULT); end
      n_vec++; if (ROLLS !== 16'(m_rolls)) begin n_err++; $display("FAIL unstable_rolls: got %0d expected %0d", ROLLS, m_rolls); end
      READY = 1'b1; tick(); READY = 1'b0;
      // dp glitch low for one sampled cycle while settling on 6.
      LEDS = 8'h5B; repeat (3) tick();
      LEDS = 8'hFC; tick(); tick();
      LEDS = 8'h7C; tick();
      LEDS = 8'hFC;
      lat = 0;
      while (!VALID && lat < 20) begin tick(); lat++; end
      model_result(7'b1111100);
      n_vec++; if (lat !== 5) begin n_err++; $display("FAIL glitch_latency: got %0d expected 5", lat); end
      n_vec++; if (RESULT !== 3'd6) begin n_err++; $display("FAIL glitch_result: got %0d expected 6", RESULT); end
      n_vec++; if (ROLLS !== 16'(m_rolls)) begin n_err++; $display("FAIL glitch_rolls: got %0d expected %0d", ROLLS, m_rolls); end
      READY = 1'b1; tick(); READY = 1'b0;
   endtask

   task automatic test_overrun();
      int lat;
      run_roll(8'h5B, 3, 7'd0, 0, 7'b1100110, lat);
      LEDS = 8'h5B; repeat (3) tick();
      m_ovr = 1'b1;
      n_vec++; if (OVR !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %0d expected 1", OVR); end
      n_vec++; if (VALID !== 1'b1 || RESULT !== 3'd4) begin n_err++; $display("FAIL ovr_hold: got v=%0d r=%0d expected v=1 r=4", VALID, RESULT); end
      READY = 1'b1; tick(); READY = 1'b0;
      n_vec++; if (VALID !== 1'b0 || OVR !== 1'b1) begin n_err++; $display("FAIL ovr_accept: got v=%0d o=%0d expected v=0 o=1", VALID, OVR); end
      run_roll(8'h5B, 2, 7'd0, 0, 7'b1101101, lat);
      n_vec++; if (lat !== 5 || RESULT !== 3'd5) begin n_err++; $display("FAIL ovr_next: got lat=%0d r=%0d expected lat=5 r=5", lat, RESULT); end
      n_vec++; if (OVR !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %0d expected 1", OVR); end
      READY = 1'b1; tick(); READY = 1'b0;
   endtask

   task automatic test_random();
      int lat, f, pre_n, wait_n, sel;
      logic [6:0] segs, pre;
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(0, 2) != 0) segs = face_pattern(int'($urandom_range(1, 6)));
         else segs = 7'($urandom);
         pre_n = int'($urandom_range(0, 3));
         pre = segs ^ 7'($urandom_range(1, 127));
         f = ref_face(segs);
         run_roll({1'b0, 7'($urandom)}, int'($urandom_range(1, 6)), pre, pre_n, segs, lat);
         n_vec++; if (lat !== 5) begin n_err++; $display("FAIL rand_latency it=%0d: got %0d expected 5", it, lat); end
         n_vec++; if (RESULT !== 3'(f) || ERR !== (f == 0)) begin
            n_err++; $display("FAIL rand_result it=%0d seg=%b: got r=%0d e=%0d expected r=%0d e=%0d", it, segs, RESULT, ERR, f, (f == 0));
         end
         wait_n = int'($urandom_range(0, 3));
         repeat (wait_n) tick();
         n_vec++; if (VALID !== 1'b1 || RESULT !== 3'(f)) begin n_err++; $display("FAIL rand_hold it=%0d: got v=%0d r=%0d expected v=1 r=%0d", it, VALID, RESULT, f); end
         READY = 1'b1; tick(); READY = 1'b0;
         n_vec++; if (VALID !== 1'b0) begin n_err++; $display("FAIL rand_accept it=%0d: got %0d expected 0", it, VALID); end
         sel = int'($urandom_range(0, 6));
         HIST_SEL = 3'(sel); #1;
         n_vec++; if (HIST_CNT !== 16'(m_tally[sel])) begin n_err++; $display("FAIL rand_hist sel=%0d: got %0d expected %0d", sel, HIST_CNT, m_tally[sel]); end
         n_vec++; if (ROLLS !== 16'(m_rolls) || OVR !== m_ovr) begin n_err++; $display("FAIL rand_rolls: got %0d/%0d expected %0d/%0d", ROLLS, OVR, m_rolls, m_ovr); end
      end
      HIST_SEL = 3'd7; #1;
      n_vec++; if (HIST_CNT !== 16'd0) begin n_err++; $display("FAIL rand_sel7: got %0d expected 0", HIST_CNT); end
   endtask

   task automatic test_saturation();
      int lat, exp_cnt;
      rst2 = 1'b1; leds2 = 8'h00; ready2 = 1'b0; sel2 = 3'd1;
      tick(); tick();
      rst2 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         leds2 = 8'h5B; repeat (3) tick();
         leds2 = 8'h86;
         lat = 0;
         while (!valid2 && lat < 20) begin tick(); lat++; end
         exp_cnt = (k > 3) ? 3 : k;
         n_vec++; if (lat !== 5 || result2 !== 3'd1) begin n_err++; $display("FAIL sat_roll k=%0d: got lat=%0d r=%0d expected lat=5 r=1", k, lat, result2); end
         n_vec++; if (hist2 !== 2'(exp_cnt) || rolls2 !== 2'(exp_cnt)) begin
            n_err++; $display("FAIL sat_count k=%0d: got h=%0d rolls=%0d expected %0d", k, hist2, rolls2, exp_cnt);
         end
         ready2 = 1'b1; tick(); ready2 = 1'b0;
      end
      // Reset in the middle of settling.
      leds2 = 8'h5B; repeat (3) tick();
      leds2 = 8'hDB; tick(); tick();
      rst2 = 1'b1; tick();
      n_vec++; if (result2 !== 3'd0 || err2 !== 1'b0 || valid2 !== 1'b0 || ovr2 !== 1'b0 || rolls2 !== 2'd0) begin
         n_err++; $display("FAIL midrst_outs: got r=%0d e=%0d v=%0d o=%0d rolls=%0d expected all 0", result2, err2, valid2, ovr2, rolls2);
      end
      for (int s = 0; s < 8; s++) begin
         sel2 = 3'(s); #1;
         n_vec++; if (hist2 !== 2'd0) begin n_err++; $display("FAIL midrst_hist sel=%0d: got %0d expected 0", s, hist2); end
      end
      rst2 = 1'b0;
   endtask

   initial begin
      RST = 1'b1; LEDS = 8'h00; READY = 1'b0; HIST_SEL = 3'd0;
      rst2 = 1'b1; leds2 = 8'h00; ready2 = 1'b0; sel2 = 3'd0;
      test_reset();
      test_basic();
      test_hold();
      test_error();
      test_instability();
      test_overrun();
      test_random();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/dice_reader.md
# dice_reader

Receive-side companion to the dice roller: samples the roller's 8-bit LED bus (7 segments plus decimal point), follows each roll from its start until the display has settled, and decodes the settled segment pattern back to a face value 1..6. It presents each result on a valid/ready handshake and keeps saturating per-face tallies. It sits on the same clock as the roller, connected directly to its LED outputs, feeding a host or self-test harness.

## Interface
- STABLE_CYCLES, 4: consecutive identical settled samples required before a result is accepted; legal range 2..255.
- CNT_W, 16: width of every tally counter.

- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- LEDS  in  8  roller display; [6:0] segments a..g (bit 0 = a), [7] decimal point (0 = rolling, 1 = idle).
- RESULT  out  3  decoded face 1..6; 0 when the pattern is not a legal face.
- ERR  out  1  qualifies RESULT: settled pattern was not a legal face.
- VALID  out  1  RESULT/ERR hold a result not yet consumed.
- READY  in  1  consumer accepts the result on a cycle with VALID=1.
- OVR  out  1  sticky: a new roll started while a result was still pending.
- HIST_SEL  in  3  tally select: 0 = error tally, 1..6 = face tallies, 7 = reads zero.
- HIST_CNT  out  CNT_W  selected tally (combinational from HIST_SEL).
- ROLLS  out  CNT_W  total settled results, including errors.

## Operation
- LEDS is registered once into ledq. All decisions use ledq.
- Face decode of ledq[6:0]:
  - 0000110 = 1
  - 1011011 = 2
  - 1001111 = 3
  - 1100110 = 4
  - 1101101 = 5
  - 1111100 = 6
  - Any other pattern, including 0111111 and 0000111, is an error.
- FSM states: IDLE, ROLLING, SETTLE, HOLD. Reset enters IDLE.
- IDLE: ledq[7]=0 -> ROLLING.
- ROLLING: ledq[7]=1 -> SETTLE; snap <= ledq[6:0]; cnt <= 1.
- SETTLE, checked in priority order:
  - ledq[7]=0 -> ROLLING (re-roll; discard snapshot).
  - ledq[6:0] != snap -> snap <= ledq[6:0]; cnt <= 1.
  - Otherwise cnt <= cnt+1.
  - When a matching sample would bring cnt to STABLE_CYCLES -> HOLD. On the same edge: latch RESULT/ERR, set VALID, ROLLS+1, increment tally[face] (or tally[0] if error).
- HOLD:
  - VALID stays 1. RESULT and ERR stay frozen.
  - VALID & READY -> IDLE; VALID deasserts on that edge.
  - If ledq[7]=0 in any HOLD cycle, OVR <= 1. The in-flight roll is not tracked separately; after acceptance, IDLE resynchronises on the next dp low.
- All counters saturate at all-ones and never wrap.
- READY is ignored when VALID=0.

## Timing
- Reset values:
  - RESULT=0, ERR=0, VALID=0, OVR=0, ROLLS=0.
  - All tallies 0; ledq=0; HIST_CNT=0 for every HIST_SEL.
- Edge numbering: the roller drives its final settled LEDS (dp=1) after edge t0; ledq captures it at t0+1.
- Latency: VALID rises at edge t0+1+STABLE_CYCLES. This is 5 edges after t0 with the default parameter.
- Tallies and ROLLS update on the same edge VALID rises, so HIST_CNT reflects the new count in the first VALID cycle.
- Handshake: the transfer completes on the first edge with VALID=1 and READY=1. The earliest next VALID is one full roll later.
- RST asserted in any state returns to IDLE next edge, clears tallies and OVR, and drops VALID without a transfer.
- A dp glitch low for one sampled cycle during SETTLE restarts the roll tracking; no result is produced for the glitched pattern.

## Test plan
- Reset, then LEDS=0x5B (dp=0) for 10 cycles, then 0xE6 held: VALID rises exactly 5 edges after LEDS changes, with RESULT=4, ERR=0, ROLLS=1, and HIST_SEL=4 gives HIST_CNT=1.
- Settle on 0xFC with READY held low for 20 cycles: VALID, RESULT=6 and ERR stay constant throughout. Raise READY for 1 cycle: VALID drops on that edge and the FSM is back in IDLE.
- Roll settling on 0xBF (pattern 0, dp=1): RESULT=0, ERR=1, HIST_SEL=0 gives 1, ROLLS=1, and all face tallies remain 0.
- Pattern instability: dp=1 with 0x86 for 2 cycles, then 0xDB held → a single result RESULT=2, VALID 5 edges after 0xDB appears. A further case drops dp to 0 for one cycle mid-settle → no result until dp returns high and the pattern is stable again.
- Roll with LEDS=0x5B while HOLD is pending: OVR=1 and stays 1 after acceptance. The next complete roll is still decoded correctly.
- With CNT_W=2, run 5 rolls all settling on face 1: HIST_SEL=1 gives 3 (saturated) and ROLLS=3. Assert RST mid-SETTLE: all outputs return to 0 on the next edge.
